seven_seg_mux_driver: RTL

//  Time-multiplexed driver for a DIGITS-wide 7-segment display bank sharing one segment bus.

---
 rtl/seven_seg_mux_driver.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed 7-segment display driver with blanking gaps,
// leading-zero suppression and frame-synchronous double buffering.
module seven_seg_mux_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1,
    parameter int BLANK_LZ     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW   = 5 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Buffers hold {value, dp}: dp in the low DIGITS bits, nibbles above.
    logic [1:0]        state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     disp, disp_n;
    logic [BW-1:0]     pend, pend_n;
    logic              pend_vld, pend_vld_n;
    logic              fd_n;
    logic              take;
    logic [BW-1:0]     live;

    logic [DIGITS-1:0] lz;
    logic [DIGITS-1:0] disp_dp;
    logic [3:0]        nib;
    logic [6:0]        segs;
    logic              lit;
    logic [7:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] an_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    assign live = {value, dp};

    // Scan sequencing, load capture and frame-boundary buffer swap.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        disp_n     = disp;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        fd_n       = 1'b0;
        take       = 1'b0;

        if (load) begin
            pend_n     = live;
            pend_vld_n = 1'b1;
        end

        if (!en) begin
            state_n = S_IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                    take    = 1'b1;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt_n   = '0;
                        state_n = S_SHOW;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_n   = '0;
                        state_n = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                        if (idx == IDX_LAST) begin
                            idx_n = '0;
                            fd_n  = 1'b1;
                            take  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end

        // A same-cycle load wins over an older pending value.
        if (take) begin
            if (load) begin
                disp_n     = live;
                pend_vld_n = 1'b0;
            end else if (pend_vld) begin
                disp_n     = pend;
                pend_vld_n = 1'b0;
            end
        end
    end

    // Next-cycle pad levels, derived from next state so outputs track state with no lag.
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (disp_n[BW-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] & (disp_n[DIGITS + 4*i +: 4] == 4'h0);
        end
        disp_dp = disp_n[DIGITS-1:0];
        nib     = disp_n[DIGITS + 4*int'(idx_n) +: 4];
        segs    = hex7(nib);
        if (BLANK_LZ != 0 && idx_n != '0 && lz[idx_n]) begin
            segs = 7'h00;
        end
        lit     = (state_n == S_SHOW);
        seg_raw = lit ? {disp_dp[idx_n], segs} : 8'h00;
        an_raw  = lit ? (DIGITS'(1) << idx_n) : '0;
        seg_d   = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
        an_d    = (DIG_ACT_LOW != 0) ? ~an_raw : an_raw;
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            disp       <= disp_n;
            pend       <= pend_n;
            pend_vld   <= pend_vld_n;
            seg        <= seg_d;
            an         <= an_d;
            frame_done <= fd_n;
        end
    end

endmodule
